// File: rtl/nvme_arb_pkg.sv
// Shared types and default sizing for the NVMe staging-FIFO write arbiter.
package nvme_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  localparam int NVME_DATA_WIDTH = 540;
  localparam int NVME_MAX_BEATS  = 16;

endpackage

// File: rtl/nvme_fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request at or above ptr, with wrap.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [ID_W-1:0]    gnt_id,
  output logic               any
);

  logic found;
  int   idx;

  always_comb begin
    gnt_id = '0;
    found  = 1'b0;
    idx    = 0;
    any    = |req;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!found && req[idx]) begin
        gnt_id = ID_W'(idx);
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/nvme_fifo_wr_arbiter.sv
// Round-robin burst arbiter for the write port of an NVMe staging FIFO.
// A granted requester owns the port until its last beat, so bursts never interleave.
module nvme_fifo_wr_arbiter
  import nvme_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = NVME_DATA_WIDTH,
  parameter int MAX_BEATS  = NVME_MAX_BEATS,
  parameter int ID_W       = $clog2(NUM_REQ)
) (
  input  logic                          wrclk,
  input  logic                          aclr,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [DATA_WIDTH-1:0]         fifo_data,
  output logic                          fifo_wrreq,
  input  logic                          fifo_wrfull,
  output logic                          grant_valid,
  output logic [ID_W-1:0]               grant_id,
  output logic                          err_overlong,
  output logic [31:0]                   beats_total
);

  localparam int BEAT_W = $clog2(MAX_BEATS + 1);

  arb_state_e       state;
  logic [ID_W-1:0]  owner;
  logic [ID_W-1:0]  rr_ptr;
  logic [BEAT_W-1:0] beat_cnt;
  logic [ID_W-1:0]  pick_id;
  logic             pick_any;
  logic             in_burst;
  logic             owner_last;
  logic [ID_W-1:0]  next_ptr;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_pick (
    .req    (req_valid),
    .ptr    (rr_ptr),
    .gnt_id (pick_id),
    .any    (pick_any)
  );

  // Reset overrides the handshake immediately so nothing is written while aclr is high.
  assign in_burst    = (state == BURST) && !aclr;
  assign owner_last  = req_last[owner];
  assign fifo_data   = req_data[owner*DATA_WIDTH +: DATA_WIDTH];
  assign fifo_wrreq  = in_burst && req_valid[owner] && !fifo_wrfull;
  assign grant_valid = in_burst;
  assign grant_id    = in_burst ? owner : '0;
  assign next_ptr    = (owner == ID_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;

  always_comb begin
    req_ready = '0;
    if (in_burst && !fifo_wrfull) req_ready[owner] = 1'b1;
  end

  always_ff @(posedge wrclk) begin
    if (aclr) begin
      state        <= IDLE;
      owner        <= '0;
      rr_ptr       <= '0;
      beat_cnt     <= '0;
      err_overlong <= 1'b0;
      beats_total  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_any) begin
            owner    <= pick_id;
            state    <= BURST;
            beat_cnt <= '0;
          end
        end
        BURST: begin
          if (fifo_wrreq) begin
            beats_total <= beats_total + 32'd1;
            if (beat_cnt != BEAT_W'(MAX_BEATS)) beat_cnt <= beat_cnt + 1'b1;
            if ((beat_cnt == BEAT_W'(MAX_BEATS - 1)) && !owner_last) err_overlong <= 1'b1;
            if (owner_last) begin
              state  <= IDLE;
              rr_ptr <= next_ptr;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nvme_fifo_wr_arbiter.sv
// Directed bench: behavioural requesters feed bursts, a scoreboard checks every FIFO write.
module tb_nvme_fifo_wr_arbiter;

  localparam int NUM_REQ    = 4;
  localparam int DATA_WIDTH = 540;
  localparam int MAX_BEATS  = 16;
  localparam int ID_W       = 2;

  logic                          wrclk;
  logic                          aclr;
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_last;
  logic [NUM_REQ-1:0]            req_ready;
  logic [DATA_WIDTH-1:0]         fifo_data;
  logic                          fifo_wrreq;
  logic                          fifo_wrfull;
  logic                          grant_valid;
  logic [ID_W-1:0]               grant_id;
  logic                          err_overlong;
  logic [31:0]                   beats_total;

  int checks   = 0;
  int failures = 0;

  logic [DATA_WIDTH-1:0] exp_q[$];
  logic [NUM_REQ-1:0]    active;
  logic [NUM_REQ-1:0]    pause;
  logic [NUM_REQ-1:0]    acc;
  int                    idx[NUM_REQ];
  int                    len[NUM_REQ];
  logic [7:0]            tag[NUM_REQ];
  logic [7:0]            seq;

  nvme_fifo_wr_arbiter #(
    .NUM_REQ    (NUM_REQ),
    .DATA_WIDTH (DATA_WIDTH),
    .MAX_BEATS  (MAX_BEATS),
    .ID_W       (ID_W)
  ) dut (
    .wrclk        (wrclk),
    .aclr         (aclr),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_last     (req_last),
    .req_ready    (req_ready),
    .fifo_data    (fifo_data),
    .fifo_wrreq   (fifo_wrreq),
    .fifo_wrfull  (fifo_wrfull),
    .grant_valid  (grant_valid),
    .grant_id     (grant_id),
    .err_overlong (err_overlong),
    .beats_total  (beats_total)
  );

  initial begin
    wrclk = 1'b0;
    forever #5 wrclk = ~wrclk;
  end

  function automatic logic [DATA_WIDTH-1:0] mk(int r, logic [7:0] t, int b);
    logic [DATA_WIDTH-1:0] d;
    d = '0;
    d[7:0]   = 8'(b);
    d[15:8]  = t;
    d[23:16] = 8'(r);
    d[DATA_WIDTH-1 -: 8] = t ^ 8'h5A;
    return d;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic load(int r, int n);
    seq++;
    tag[r]    = seq;
    len[r]    = n;
    idx[r]    = 0;
    active[r] = 1'b1;
    for (int b = 0; b < n; b++) exp_q.push_back(mk(r, seq, b));
  endtask

  task automatic wait_idx(int r, int v, string nm);
    int n;
    n = 0;
    while (idx[r] != v && n < 300) begin
      @(negedge wrclk);
      n++;
    end
    chk({nm, "_timeout"}, (n >= 300) ? 64'd1 : 64'd0, 64'd0);
  endtask

  task automatic wait_done(string nm);
    int n;
    n = 0;
    while ((active != '0 || grant_valid) && n < 500) begin
      @(negedge wrclk);
      n++;
    end
    chk({nm, "_timeout"}, (n >= 500) ? 64'd1 : 64'd0, 64'd0);
  endtask

  // Requester models: update 2 after the edge, sample handshake 2 before the next edge.
  initial begin
    acc       = '0;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    forever begin
      @(posedge wrclk);
      #2;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (acc[i]) begin
          if (idx[i] == len[i] - 1) active[i] = 1'b0;
          idx[i]++;
        end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        req_valid[i] = active[i] && !pause[i];
        req_last[i]  = (idx[i] == len[i] - 1);
        req_data[i*DATA_WIDTH +: DATA_WIDTH] = mk(i, tag[i], idx[i]);
      end
      #6;
      acc = req_valid & req_ready & ~{NUM_REQ{aclr}};
    end
  end

  // Scoreboard monitor: every FIFO write must match the next expected beat.
  initial begin
    logic [DATA_WIDTH-1:0] e;
    forever begin
      @(posedge wrclk);
      #8;
      if (fifo_wrreq) begin
        checks++;
        if (fifo_wrfull) begin
          failures++;
          $display("FAIL wr_while_full got=1 exp=0");
        end else if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_write data_lo=%0h", fifo_data[31:0]);
        end else begin
          e = exp_q.pop_front();
          if (fifo_data !== e) begin
            failures++;
            $display("FAIL fifo_data got_lo=%0h got_hi=%0h exp_lo=%0h exp_hi=%0h",
                     fifo_data[31:0], fifo_data[DATA_WIDTH-1 -: 8], e[31:0], e[DATA_WIDTH-1 -: 8]);
          end
        end
      end
    end
  end

  initial begin
    seq         = '0;
    active      = '0;
    pause       = '0;
    fifo_wrfull = 1'b0;
    aclr        = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx[i] = 0;
      len[i] = 0;
      tag[i] = '0;
    end
    repeat (3) @(posedge wrclk);
    #1 aclr = 1'b0;
    @(negedge wrclk);
    chk("rst_grant_valid", 64'(grant_valid), 64'd0);
    chk("rst_beats_total", 64'(beats_total), 64'd0);
    chk("rst_err", 64'(err_overlong), 64'd0);
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_wrreq", 64'(fifo_wrreq), 64'd0);

    // Single requester, 3-beat burst.
    @(posedge wrclk);
    #1 load(2, 3);
    @(negedge wrclk);
    chk("t1_no_grant_yet", 64'(grant_valid), 64'd0);
    @(negedge wrclk);
    chk("t1_grant_valid", 64'(grant_valid), 64'd1);
    chk("t1_grant_id", 64'(grant_id), 64'd2);
    chk("t1_ready", 64'(req_ready), 64'b0100);
    chk("t1_wrreq", 64'(fifo_wrreq), 64'd1);
    repeat (3) @(negedge wrclk);
    chk("t1_idle", 64'(grant_valid), 64'd0);
    chk("t1_beats_total", 64'(beats_total), 64'd3);
    chk("t1_rr_ptr", 64'(dut.rr_ptr), 64'd3);

    // Reset rr_ptr, then four simultaneous 2-beat bursts; grant order 0,1,2,3.
    @(posedge wrclk);
    #1 aclr = 1'b1;
    @(posedge wrclk);
    #1 aclr = 1'b0;
    for (int r = 0; r < NUM_REQ; r++) load(r, 2);
    @(negedge wrclk);
    @(negedge wrclk);
    chk("t2_first_grant", 64'(grant_id), 64'd0);
    wait_done("t2");
    chk("t2_beats_total", 64'(beats_total), 64'd8);

    // FIFO full for 5 cycles mid-burst.
    @(posedge wrclk);
    #1 load(1, 4);
    wait_idx(1, 2, "t3_idx");
    @(posedge wrclk);
    #1 fifo_wrfull = 1'b1;
    repeat (5) begin
      @(negedge wrclk);
      chk("t3_stall_wrreq", 64'(fifo_wrreq), 64'd0);
      chk("t3_stall_ready", 64'(req_ready), 64'd0);
      chk("t3_stall_owner", 64'(grant_id), 64'd1);
    end
    @(posedge wrclk);
    #1 fifo_wrfull = 1'b0;
    wait_done("t3");
    chk("t3_beats_total", 64'(beats_total), 64'd12);

    // 17-beat burst exceeds MAX_BEATS.
    @(posedge wrclk);
    #1 load(3, 17);
    wait_idx(3, 15, "t4_idx");
    chk("t4_err_before", 64'(err_overlong), 64'd0);
    @(negedge wrclk);
    chk("t4_err_beat16", 64'(err_overlong), 64'd1);
    wait_done("t4");
    chk("t4_err_sticky", 64'(err_overlong), 64'd1);
    chk("t4_beats_total", 64'(beats_total), 64'd29);

    // aclr after beat 2 of a 4-beat burst.
    @(posedge wrclk);
    #1 load(1, 4);
    wait_idx(1, 2, "t5_idx");
    aclr = 1'b1;
    #1;
    chk("t5_aclr_ready", 64'(req_ready), 64'd0);
    chk("t5_aclr_wrreq", 64'(fifo_wrreq), 64'd0);
    chk("t5_aclr_gv", 64'(grant_valid), 64'd0);
    @(posedge wrclk);
    #1 aclr = 1'b0;
    @(negedge wrclk);
    chk("t5_idle", 64'(grant_valid), 64'd0);
    chk("t5_beats_total", 64'(beats_total), 64'd0);
    chk("t5_err", 64'(err_overlong), 64'd0);
    chk("t5_rr_ptr", 64'(dut.rr_ptr), 64'd0);
    @(negedge wrclk);
    chk("t5_regrant", 64'(grant_valid), 64'd1);
    chk("t5_regrant_id", 64'(grant_id), 64'd1);
    wait_done("t5");
    chk("t5_beats_after", 64'(beats_total), 64'd2);

    // Owner pauses mid-burst while req 0 waits.
    @(posedge wrclk);
    #1 begin
      load(2, 4);
      load(0, 2);
    end
    wait_idx(2, 2, "t6_idx");
    @(posedge wrclk);
    #1 pause[2] = 1'b1;
    repeat (3) begin
      @(negedge wrclk);
      chk("t6_hold_id", 64'(grant_id), 64'd2);
      chk("t6_hold_gv", 64'(grant_valid), 64'd1);
      chk("t6_hold_wrreq", 64'(fifo_wrreq), 64'd0);
      chk("t6_req0_ready", 64'(req_ready[0]), 64'd0);
    end
    @(posedge wrclk);
    #1 pause[2] = 1'b0;
    wait_done("t6");
    chk("t6_beats_total", 64'(beats_total), 64'd8);

    repeat (2) @(negedge wrclk);
    chk("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/nvme_fifo_wr_arbiter.md
Name: nvme_fifo_wr_arbiter

Overview:
- Shares the write side of one NVMe staging FIFO among NUM_REQ requesters using round-robin arbitration.
- Each requester presents multi-beat entries (bursts) with valid/ready/last.
- A granted requester holds the FIFO until its last beat is written, so bursts never interleave.
- Sits between the requester queues and the FIFO's data/wrreq/wrfull write port, on the FIFO write clock.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_WIDTH, 540, FIFO entry width in bits.
- MAX_BEATS, 16, longest legal burst in beats; a longer burst raises err_overlong.
- ID_W, $clog2(NUM_REQ), width of the grant index.

Ports:
- wrclk  in  1  clock, shared with the FIFO write side.
- aclr  in  1  reset, synchronous, active-high.
- req_valid  in  NUM_REQ  per-requester beat valid.
- req_data  in  NUM_REQ*DATA_WIDTH  per-requester beat data; requester i occupies slice [i*DATA_WIDTH +: DATA_WIDTH].
- req_last  in  NUM_REQ  marks the final beat of a burst.
- req_ready  out  NUM_REQ  beat accepted when req_valid[i] and req_ready[i] are both high.
- fifo_data  out  DATA_WIDTH  to FIFO data.
- fifo_wrreq  out  1  to FIFO wrreq.
- fifo_wrfull  in  1  from FIFO wrfull.
- grant_valid  out  1  a burst is in progress.
- grant_id  out  ID_W  current owner; 0 when idle.
- err_overlong  out  1  sticky; cleared only by aclr.
- beats_total  out  32  count of beats written to the FIFO; wraps modulo 2^32.

Behaviour:
- State machine: IDLE, BURST.
- IDLE:
  - If any req_valid is set, grant the first set requester searching from rr_ptr upward, with wrap.
  - On grant: owner <= that index, state <= BURST, beat_cnt <= 0.
  - No beat is accepted in IDLE, so each burst costs one bubble cycle.
- BURST, combinational outputs:
  - req_ready[owner] = !fifo_wrfull; all other req_ready bits are 0.
  - fifo_wrreq = req_valid[owner] & !fifo_wrfull.
  - fifo_data = req_data[owner] (also driven in IDLE; don't-care when fifo_wrreq = 0).
  - Zero-latency pass-through, so no write is ever issued while wrfull is high and no data is lost.
- Beat accepted (fifo_wrreq = 1):
  - beats_total increments.
  - beat_cnt increments, saturating at MAX_BEATS.
  - If req_last[owner] is set: state <= IDLE, rr_ptr <= owner+1 mod NUM_REQ.
- Overlong burst:
  - If a beat is accepted while beat_cnt == MAX_BEATS-1 and req_last is 0, set err_overlong.
  - The grant is kept until last; the block never preempts.
- Owner deasserts valid mid-burst: the grant is held and the block waits indefinitely.
- wrfull in BURST: stall; req_ready is 0 and fifo_wrreq is 0. State and beat_cnt are unchanged.
- Simultaneous requests: strict round-robin, so each requester waits for at most NUM_REQ-1 bursts.
- Reset values: state IDLE, rr_ptr 0, owner 0, beat_cnt 0, err_overlong 0, beats_total 0.
- While aclr is high:
  - req_ready = 0, fifo_wrreq = 0, grant_valid = 0, regardless of state.
  - A burst in progress is abandoned; the next grant starts fresh.
  - The FIFO is expected to be cleared by the same aclr.
- grant_valid = (state == BURST). grant_id = owner in BURST, 0 in IDLE.

Decomposition:
- Package nvme_arb_pkg holds:
  - arb_state_e enum (IDLE, BURST);
  - default constants NVME_DATA_WIDTH = 540 and NVME_MAX_BEATS = 16.
- One sub-module, rr_pick: combinational round-robin selector.
  - Inputs: req[NUM_REQ], ptr[ID_W].
  - Outputs: gnt_id[ID_W], any.
- The top module holds the FSM, owner mux and counters.

Test Plan:
- Single requester: req 2 sends a 3-beat burst while the FIFO is never full. Expected:
  - grant on cycle 1, beats written on cycles 2-4 with fifo_wrreq high;
  - req_ready[2] is the only ready bit set;
  - state returns to IDLE, rr_ptr = 3, beats_total = 3.
- All four requesters valid, each sending 2-beat bursts, starting with rr_ptr = 0. Expected:
  - grant order 0,1,2,3;
  - FIFO contents never interleave, shown by each beat's data tag matching its burst;
  - beats_total = 8.
- fifo_wrfull forced high for 5 cycles in the middle of a 4-beat burst. Expected:
  - fifo_wrreq = 0 and req_ready = 0 throughout the stall;
  - the burst completes afterwards with the same owner and no lost or duplicated beat.
- 17-beat burst with last set only on beat 17 (MAX_BEATS = 16). Expected:
  - err_overlong rises on the accept cycle of beat 16 and stays set;
  - all 17 beats are written.
- aclr asserted for 1 cycle after beat 2 of a 4-beat burst. Expected:
  - the same cycle shows req_ready = 0 and fifo_wrreq = 0;
  - next cycle: state IDLE, beats_total = 0, err_overlong = 0, rr_ptr = 0;
  - a fresh grant follows if any req_valid is set.
- Owner drops req_valid for 3 cycles mid-burst while req 0 is valid. Expected:
  - grant_id stays unchanged and req 0 is not granted;
  - the burst resumes when the owner reasserts valid.
